// File: rtl/mips_harvard_data_mem_pkg.sv
// mips_mem_pkg: shared state type, default geometry and address-range helper
package mips_mem_pkg;
    typedef enum logic {LOAD, RUN} state_t;
    localparam int          DEF_DEPTH = 1024;
    localparam logic [31:0] DEF_BASE  = 32'h0000_1000;
    function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base, input int depth);
        logic [32:0] w_lim;
        w_lim = {1'b0, base} + 33'(4 * depth);
        return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < w_lim);
    endfunction
endpackage

// File: rtl/mips_harvard_data_mem_if.sv
// mips_harvard_data_mem_if: CPU data port, boot-load stream and status; master = CPU/loader side, slave = memory
interface mips_harvard_data_mem_if;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_last;
    logic        load_ready;
    logic        cpu_reset;
    logic        access_error;
    logic [15:0] access_count;
    modport master (
        output data_address, data_read, data_write, data_writedata, load_valid, load_byte, load_last,
        input  data_readdata, load_ready, cpu_reset, access_error, access_count
    );
    modport slave (
        input  data_address, data_read, data_write, data_writedata, load_valid, load_byte, load_last,
        output data_readdata, load_ready, cpu_reset, access_error, access_count
    );
endinterface

// File: rtl/mips_harvard_data_mem_packer.sv
// mips_load_packer: packs boot bytes little-endian into words; ports i_accept/i_byte/i_last in, o_word/o_we/o_done out
module mips_load_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    input  logic        i_last,
    output logic [31:0] o_word,
    output logic        o_we,
    output logic        o_done
);
    logic [1:0]  r_lane;
    logic [31:0] r_asm;
    logic [31:0] w_merged;
    // r_asm is cleared after every word, so lanes not yet filled read as zero on a short final word
    always_comb begin
        w_merged = r_asm;
        w_merged[8*r_lane +: 8] = i_byte;
    end
    assign o_word = w_merged;
    assign o_we   = i_accept && (r_lane == 2'd3 || i_last);
    assign o_done = i_accept && i_last;
    always_ff @(posedge clk) begin
        if (reset || o_we) begin
            r_lane <= 2'd0;
            r_asm  <= '0;
        end else if (i_accept) begin
            r_lane <= r_lane + 2'd1;
            r_asm  <= w_merged;
        end
    end
endmodule

// File: rtl/mips_harvard_data_mem.sv
// mips_harvard_data_mem: boot-loaded word RAM serving the CPU data port; ports clk, reset, bus (slave modport)
module mips_harvard_data_mem
    import mips_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = DEF_DEPTH,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE
) (
    input logic                    clk,
    input logic                    reset,
    mips_harvard_data_mem_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    state_t        r_state;
    logic [AW:0]   r_ptr;
    logic          r_err;
    logic [15:0]   r_cnt;
    logic [31:0]   r_mem [DEPTH_WORDS];
    logic          w_run, w_ready, w_inr, w_strobe;
    logic          w_pk_we, w_pk_done, w_we;
    logic [31:0]   w_pk_word, w_wdata;
    logic [AW-1:0] w_idx, w_waddr;
    assign w_run    = r_state == RUN;
    assign w_ready  = r_state == LOAD && !r_ptr[AW];
    assign w_inr    = in_range(bus.data_address, BASE_ADDR, DEPTH_WORDS);
    assign w_idx    = AW'((bus.data_address - BASE_ADDR) >> 2);
    assign w_strobe = w_run && (bus.data_read || bus.data_write);
    mips_load_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .i_accept (bus.load_valid && w_ready),
        .i_byte   (bus.load_byte),
        .i_last   (bus.load_last),
        .o_word   (w_pk_word),
        .o_we     (w_pk_we),
        .o_done   (w_pk_done)
    );
    // one shared write port: the loader owns it in LOAD, the CPU in RUN
    assign w_we    = w_run ? (bus.data_write && w_inr) : w_pk_we;
    assign w_waddr = w_run ? w_idx : r_ptr[AW-1:0];
    assign w_wdata = w_run ? bus.data_writedata : w_pk_word;
    always_ff @(posedge clk)
        if (w_we) r_mem[w_waddr] <= w_wdata;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= LOAD;
            r_ptr   <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == LOAD) begin
            if (w_pk_we) r_ptr <= r_ptr + (AW+1)'(1);
            if (w_pk_done) r_state <= RUN;
            else if (r_ptr[AW]) begin
                r_err   <= 1'b1;
                r_state <= RUN;
            end
        end else begin
            if (w_strobe) r_cnt <= r_cnt + 16'd1;
            if (w_strobe && !w_inr) r_err <= 1'b1;
        end
    end
    assign bus.data_readdata = (w_run && bus.data_read && w_inr) ? r_mem[w_idx] : 32'd0;
    assign bus.load_ready    = w_ready;
    assign bus.cpu_reset     = !w_run;
    assign bus.access_error  = r_err;
    assign bus.access_count  = r_cnt;
endmodule

// File: doc/mips_harvard_data_mem.md
Name: mips_harvard_data_mem

Overview:
- Responder for the CPU's Harvard data port: a word-wide RAM that answers data_read and data_write from the CPU.
- Has a boot-load front end that fills the RAM from a byte stream while the CPU is held in reset.
- Releases the CPU when loading completes, then serves loads and stores.
- Flags out-of-range accesses and counts accesses for the bench.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two.
- BASE_ADDR, 32'h0000_1000, byte address of word 0; must be aligned to 4*DEPTH_WORDS.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- data_address  in  32  CPU byte address; bits [1:0] ignored
- data_read  in  1  CPU read strobe
- data_write  in  1  CPU write strobe
- data_writedata  in  32  CPU store word
- data_readdata  out  32  read word, combinational
- load_valid  in  1  boot byte valid
- load_byte  in  8  boot byte
- load_last  in  1  marks the final boot byte
- load_ready  out  1  boot byte accepted when load_valid=1 and load_ready=1
- cpu_reset  out  1  drives the CPU reset
- access_error  out  1  sticky error flag
- access_count  out  16  wrapping count of accepted CPU accesses

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Reset values: state=LOAD, load pointer=0, byte lane=0, assembly register=0, access_error=0, access_count=0. RAM contents are NOT cleared.
- State LOAD:
  - cpu_reset=1; load_ready=1 while pointer<DEPTH_WORDS.
  - Each accepted byte goes into lane byte_idx of the assembly word (byte0 -> [7:0], byte3 -> [31:24]). This matches the little-endian memory image the CPU byte-swaps.
  - On acceptance of the 4th byte: word written to mem[pointer] at that edge; pointer+1; lane returns to 0.
  - load_last on an accepted byte: the partial word is written with unfilled lanes zero, the pointer advances, and state becomes RUN at the same edge.
  - Pointer reaching DEPTH_WORDS without load_last: load_ready=0, access_error set, state becomes RUN on the next edge.
  - CPU strobes in LOAD: ignored; data_readdata=0; not counted.
- State RUN:
  - cpu_reset=0 (decoded from the state register, so it is glitch-free). The CPU has seen reset high for at least one edge because LOAD lasts at least one cycle.
  - load_ready=0; further load bytes are ignored.
- Address decode:
  - In range when BASE_ADDR <= addr < BASE_ADDR+4*DEPTH_WORDS.
  - Index = (addr-BASE_ADDR)[log2(DEPTH)+1:2].
- Read:
  - data_readdata = mem[index] when state=RUN, data_read=1 and the address is in range; otherwise 0.
  - Zero latency, no wait states. The CPU samples the data in the same cycle.
- Write:
  - At posedge, when RUN, data_write=1 and in range: mem[index] <= data_writedata. Full word only; the CPU performs byte and half stores by read-modify-write across two cycles.
- Simultaneous read and write in one cycle: the read returns the pre-edge contents, the write lands at the edge, and access_count increments by 1.
- Back-to-back read (cycle N) then write (cycle N+1) to the same word: the read-modify-write case. The cycle N+2 read must return the new word.
- Out-of-range strobe in RUN: no write, readdata=0, access_error set at the edge and held until reset.
- access_count: +1 at each edge where RUN and (data_read or data_write); wraps at 16'hFFFF -> 0.
- Reset mid-LOAD or mid-RUN: restart in LOAD with pointer 0; cpu_reset=1 from the first reset edge.

Decomposition:
- Package mips_mem_pkg holds:
  - the state enum (LOAD, RUN);
  - the default BASE_ADDR and DEPTH constants;
  - a function in_range(addr, base, depth).
- Sub-module mips_load_packer: byte lane counter, assembly register and the word-complete/last strobes. Its outputs are a word, a write strobe and a done flag.
- The parent holds the RAM array, the FSM, the decode, the error flag and the counter.

Test Plan:
- Reset, then stream bytes 78,56,34,12,EF,BE,AD,DE with last on byte 8 -> mem[0]=32'h12345678, mem[1]=32'hDEADBEEF; cpu_reset drops the cycle after the last byte.
- Stream 3 bytes AA,BB,CC with last on the 3rd -> mem[0]=32'h00CCBBAA; RUN entered; load_ready=0.
- RUN: write 32'hCAFEF00D to 32'h0000_1004 -> read of 32'h0000_1004 returns 32'hCAFEF00D; read of 32'h0000_1006 returns the same word.
- RUN: read from 32'h0000_0FFC, then from 32'h0000_1000+4*DEPTH -> data_readdata=0 both times; access_error=1 and stays 1; the RAM is unchanged.
- RUN: read then write to the same address on consecutive cycles (the SB sequence), then a third read -> old value, then new value; access_count increases by 3.
- Stream 4*DEPTH+2 bytes with no last -> load_ready falls after 4*DEPTH bytes, access_error=1, RUN entered; assert reset mid-RUN -> cpu_reset=1, load_ready=1, access_count=0.
